// File: rtl/txbl_console_writer.sv
// Text console writer: turns a byte stream into TXBL tile writes through the
// VRAM write port, with cursor tracking, hardware clear and one-row scroll.
module txbl_console_writer #(
  parameter logic [11:0] TXBL_BASE = 12'h900,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned COLS      = 32
) (
  input  logic        cpu_clk,
  input  logic        rst_n,
  input  logic [7:0]  char_i,
  input  logic        color_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [11:0] vram_address_o,
  output logic [7:0]  vram_wdata_o,
  input  logic [7:0]  vram_rdata_i,
  output logic        vram_wen_o,
  output logic        SELECT_txbl_o,
  output logic [4:0]  cursor_row_o,
  output logic [4:0]  cursor_col_o,
  output logic        busy_o
);

  localparam logic [4:0] LastRow      = 5'(ROWS - 1);
  localparam logic [4:0] LastCol      = 5'(COLS - 1);
  localparam logic [9:0] LastTile     = 10'(ROWS * COLS - 1);
  localparam logic [9:0] ScrollFirst  = 10'(COLS);
  localparam logic [9:0] LastRowFirst = 10'((ROWS - 1) * COLS);

  typedef enum logic [2:0] {
    StIdle, StPut, StClear, StScrollRd, StScrollWr, StScrollClr
  } state_e;

  state_e      state_q;
  logic [4:0]  row_q, col_q;
  logic [9:0]  cnt_q;
  logic [11:0] addr_q;
  logic [7:0]  wdata_q;

  function automatic logic [11:0] tile_addr(input logic [9:0] idx);
    return TXBL_BASE + {2'b00, idx};
  endfunction

  // Single FSM: state, cursor, tile counter and the registered bus address/data.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (char_valid_i) begin
            if (char_i >= 8'h20 && char_i <= 8'h7E) begin
              state_q <= StPut;
              addr_q  <= tile_addr({row_q, col_q});
              wdata_q <= {color_i, char_i[6:0]};
            end else begin
              case (char_i)
                8'h0A: begin
                  col_q <= '0;
                  if (row_q == LastRow) begin
                    // Scroll source starts at row 1, col 0.
                    state_q <= StScrollRd;
                    cnt_q   <= ScrollFirst;
                    addr_q  <= tile_addr(ScrollFirst);
                  end else begin
                    row_q <= row_q + 5'd1;
                  end
                end
                8'h0D: col_q <= '0;
                8'h08: begin
                  if (col_q != 5'd0) begin
                    col_q <= col_q - 5'd1;
                  end else if (row_q != 5'd0) begin
                    row_q <= row_q - 5'd1;
                    col_q <= LastCol;
                  end
                end
                8'h0C: begin
                  state_q <= StClear;
                  cnt_q   <= '0;
                  addr_q  <= tile_addr(10'd0);
                  wdata_q <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        StPut: begin
          if (bus_gnt_i) begin
            if (col_q == LastCol) begin
              col_q <= '0;
              if (row_q == LastRow) begin
                state_q <= StScrollRd;
                cnt_q   <= ScrollFirst;
                addr_q  <= tile_addr(ScrollFirst);
              end else begin
                row_q   <= row_q + 5'd1;
                state_q <= StIdle;
              end
            end else begin
              col_q   <= col_q + 5'd1;
              state_q <= StIdle;
            end
          end
        end
        StScrollRd: begin
          if (bus_gnt_i) begin
            wdata_q <= vram_rdata_i;
            addr_q  <= addr_q - 12'(COLS);
            state_q <= StScrollWr;
          end
        end
        StScrollWr: begin
          if (bus_gnt_i) begin
            if (cnt_q == LastTile) begin
              cnt_q   <= LastRowFirst;
              addr_q  <= tile_addr(LastRowFirst);
              wdata_q <= '0;
              state_q <= StScrollClr;
            end else begin
              cnt_q   <= cnt_q + 10'd1;
              addr_q  <= tile_addr(cnt_q + 10'd1);
              state_q <= StScrollRd;
            end
          end
        end
        StClear, StScrollClr: begin
          if (bus_gnt_i) begin
            if (cnt_q == LastTile) begin
              if (state_q == StClear) begin
                row_q <= '0;
                col_q <= '0;
              end
              state_q <= StIdle;
            end else begin
              cnt_q  <= cnt_q + 10'd1;
              addr_q <= tile_addr(cnt_q + 10'd1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic wr_state;

  // Output decode from the registered state; write strobe qualified by grant.
  always_comb begin
    wr_state = (state_q == StPut) || (state_q == StClear) ||
               (state_q == StScrollWr) || (state_q == StScrollClr);
    char_ready_o   = (state_q == StIdle);
    bus_req_o      = ~char_ready_o;
    SELECT_txbl_o  = bus_req_o;
    busy_o         = bus_req_o;
    vram_wen_o     = wr_state & bus_gnt_i;
    vram_address_o = addr_q;
    vram_wdata_o   = wdata_q;
    cursor_row_o   = row_q;
    cursor_col_o   = col_q;
  end

endmodule

// File: doc/txbl_console_writer.md
Name: txbl_console_writer

Overview:
- Hardware text console that writes into the Text Table (TXBL) through the VRAM write port, on the CPU side of the text layer.
- Accepts a byte stream over a valid/ready handshake and tracks a cursor over the 30x32 visible grid.
- Handles a set of control codes, and performs hardware clear and one-row scroll by reading TXBL back and rewriting it.
- Sits between a CPU-facing stream source and the GPU VRAM arbiter.

Parameters:
- TXBL_BASE, 12'h900, VRAM address of TXBL tile (row 0, col 0); tile address = TXBL_BASE + {row[4:0], col[4:0]}
- ROWS, 30, visible text rows
- COLS, 32, text columns; fixed, because the address is formed by concatenation

Ports:
- cpu_clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- char_i  in  8  input byte
- color_i  in  1  colorselect for the byte, sampled with char_i
- char_valid_i  in  1  byte offered
- char_ready_o  out  1  writer can accept a byte
- bus_req_o  out  1  writer requests the VRAM port
- bus_gnt_i  in  1  VRAM port granted this cycle
- vram_address_o  out  12  VRAM address (mapache64::vram_address_t)
- vram_wdata_o  out  8  tile byte {colorselect, pmca[6:0]}
- vram_rdata_i  in  8  combinational TXBL read data for vram_address_o
- vram_wen_o  out  1  write strobe; the text layer commits it on the following negedge
- SELECT_txbl_o  out  1  high whenever bus_req_o is high
- cursor_row_o  out  5  current cursor row, 0..29
- cursor_col_o  out  5  current cursor column, 0..31
- busy_o  out  1  equals bus_req_o

Behaviour:
- Reset (asynchronous): state IDLE, cursor (0,0), char_ready_o=1, bus_req_o=0, vram_wen_o=0, SELECT_txbl_o=0, vram_address_o=0, vram_wdata_o=0. Asserting reset mid-operation aborts immediately; the tiles already written remain.
- Handshake: a byte is accepted on a posedge with char_valid_i & char_ready_o. char_ready_o=1 only in IDLE. It drops the cycle after acceptance.
- Bus: in every non-IDLE state bus_req_o=1. A state advances only on a cycle with bus_gnt_i=1. vram_wen_o = write-state & bus_gnt_i. With bus_gnt_i=0 the outputs hold and no write occurs.
- Decode on accept:
  - 0x20..0x7E: go to PUT.
  - 0x0A: move cursor to col 0, row+1.
  - 0x0D: move cursor to col 0, same row.
  - 0x08: move back one cell. At col 0, row>0 go to (row-1, 31). At (0,0) no-op. No erase.
  - 0x0C: go to CLEAR.
  - All other bytes are ignored and consumed.
- PUT: one cycle. Writes {color, char[6:0]} at the cursor, then advances the cursor. At col 31 the cursor wraps to col 0, row+1.
- Row advance past 29 (from PUT or 0x0A) enters SCROLL; the cursor ends at (29,0).
- CLEAR: writes 8'h00 to tiles 0..959 in address order, one per granted cycle. Afterwards cursor=(0,0), go to IDLE.
- SCROLL sequence, for each tile of rows 1..29 in address order:
  - SCROLL_RD: drive the source address and latch vram_rdata_i.
  - SCROLL_WR: write the latched byte to the source address minus 32.
  - After all 928 tiles, SCROLL_CLR writes 8'h00 to row 29, cols 0..31.
  - Then go to IDLE.
- Cycle costs with continuous grant: PUT 1; CLEAR 960; SCROLL 1856+32=1888. char_ready_o returns to 1 the cycle after the last write.
- Rows 30/31 (addresses 0x900+960..0x900+1023) are never written.
- A control code that only moves the cursor takes 1 cycle in IDLE and does not request the bus. char_ready_o stays 1 during that cycle.
- Arithmetic: row/col are 5-bit. The address sum is truncated to 12 bits. Scroll indices run on one 10-bit tile counter.

Test Plan:
- Reset, then send 'A' (0x41) with color_i=1, grant tied high → one vram_wen_o pulse at 0x900 with wdata 0xC1; cursor (0,1); ready low for exactly 1 cycle.
- Send 32 printable bytes from (0,0) → writes 0x900..0x91F in order; cursor (1,0).
- Cursor at (29,5), send 0x0A; preload tile (1,3)=0x55 and (29,0)=0x7F → scroll completes after 1888 cycles. Required state: tile (0,3)=0x55, (28,0)=0x7F, row 29 all 0x00, cursor (29,0).
- Send 0x0C with bus_gnt_i toggled every other cycle → 960 writes, none on gnt-low cycles. TXBL 0..959 zero, tiles 960..1023 untouched, cursor (0,0).
- Send 0x08 at (0,0) → no write, cursor stays (0,0). Send 0x08 at (3,0) → cursor (2,31).
- Deassert rst_n halfway through CLEAR → vram_wen_o low immediately, cursor (0,0), ready=1 on release. Earlier tiles stay cleared; later tiles are unchanged.
